// File: rtl/interleave_block_input.sv
// Block interleaver: IIR blocks of N samples written block-sequentially into one
// bank of a ping-pong store, streamed out sample-interleaved from the other bank.
module interleave_block_input #(
  parameter int BITS = 8,
  parameter int IIR  = 3,
  parameter int N    = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] data_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] data_out,
  output logic            out_first,
  output logic            out_last
);

  localparam int FRAME = IIR * N;
  localparam int DEPTH = 2 * FRAME;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(IIR);
  localparam int IW    = $clog2(N);
  localparam logic [BW-1:0] BLK_MAX = BW'(IIR - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;
  state_t state_q, state_d;

  logic          wr_bank_q, wr_bank_d;
  logic [BW-1:0] wr_blk_q, wr_blk_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic          rd_bank_q, rd_bank_d;
  logic [BW-1:0] rd_blk_q, rd_blk_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [1:0]    full_q, full_d;
  logic          out_valid_q, out_valid_d;
  logic          out_first_q, out_first_d;
  logic          out_last_q, out_last_d;
  logic [BITS-1:0] data_out_q;

  logic [BITS-1:0] mem [DEPTH];
  logic            accept, load, wr_end, rd_end;
  logic [AW-1:0]   wr_addr, rd_addr;

  assign in_ready = !full_q[wr_bank_q];
  assign accept   = in_valid && in_ready;
  assign wr_end   = (wr_blk_q == BLK_MAX) && (wr_idx_q == IDX_MAX);
  assign rd_end   = (rd_blk_q == BLK_MAX) && (rd_idx_q == IDX_MAX);
  assign load     = (!out_valid_q || out_ready) && full_q[rd_bank_q];

  // Flat address: bank-major, then block, then sample within block
  assign wr_addr = AW'(int'(wr_bank_q) * FRAME + int'(wr_blk_q) * N + int'(wr_idx_q));
  assign rd_addr = AW'(int'(rd_bank_q) * FRAME + int'(rd_blk_q) * N + int'(rd_idx_q));

  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr] <= data_in;
  end

  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_blk_d  = wr_blk_q;
    wr_idx_d  = wr_idx_q;
    if (accept) begin
      if (wr_idx_q == IDX_MAX) begin
        wr_idx_d = '0;
        if (wr_blk_q == BLK_MAX) begin
          wr_blk_d  = '0;
          wr_bank_d = !wr_bank_q;
        end else begin
          wr_blk_d = wr_blk_q + 1'b1;
        end
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
  end

  // Read order walks blocks first so consecutive outputs come from different blocks
  always_comb begin
    rd_bank_d = rd_bank_q;
    rd_blk_d  = rd_blk_q;
    rd_idx_d  = rd_idx_q;
    if (load) begin
      if (rd_blk_q == BLK_MAX) begin
        rd_blk_d = '0;
        if (rd_idx_q == IDX_MAX) begin
          rd_idx_d  = '0;
          rd_bank_d = !rd_bank_q;
        end else begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
      end else begin
        rd_blk_d = rd_blk_q + 1'b1;
      end
    end
  end

  always_comb begin
    full_d      = full_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    if (accept && wr_end) full_d[wr_bank_q] = 1'b1;
    if (load && rd_end)   full_d[rd_bank_q] = 1'b0;
    if (load) begin
      out_valid_d = 1'b1;
      out_first_d = (rd_idx_q == '0) && (rd_blk_q == '0);
      out_last_d  = rd_end;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (full_q[rd_bank_q]) state_d = S_STREAM;
      S_STREAM: if (load && rd_end && !full_d[!rd_bank_q]) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_bank_q   <= 1'b0;
      wr_blk_q    <= '0;
      wr_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_blk_q    <= '0;
      rd_idx_q    <= '0;
      full_q      <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      wr_blk_q    <= wr_blk_d;
      wr_idx_q    <= wr_idx_d;
      rd_bank_q   <= rd_bank_d;
      rd_blk_q    <= rd_blk_d;
      rd_idx_q    <= rd_idx_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      if (load) data_out_q <= mem[rd_addr];
    end
  end

  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_interleave_block_input.sv
// Directed bench for interleave_block_input with IIR=3, N=4; one line per output transfer.
module tb_interleave_block_input;

  localparam int BITS  = 8;
  localparam int IIR   = 3;
  localparam int N     = 4;
  localparam int FRAME = IIR * N;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [BITS-1:0] data_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [BITS-1:0] data_out;
  logic            out_first;
  logic            out_last;

  always #5 clk = ~clk;

  interleave_block_input #(.BITS(BITS), .IIR(IIR), .N(N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .out_first(out_first),
    .out_last (out_last)
  );

  typedef struct packed {
    logic [BITS-1:0] d;
    logic            f;
    logic            l;
  } exp_t;

  exp_t            exp_q[$];
  logic [BITS-1:0] got_q[$];
  logic [BITS-1:0] in_buf[FRAME];
  int              in_cnt = 0;
  int              n_checks = 0;
  int              n_errors = 0;
  int              xfer_cnt = 0;
  int              acc_cnt = 0;
  int              tick_no = 0;
  int              first_vt = -1;
  int              last_vt = -1;
  int              vcount = 0;
  logic            hold_pending = 1'b0;
  logic [BITS-1:0] hold_data;
  logic [1:0]      hold_flags;
  logic            obs_valid, obs_first, obs_last, obs_in_ready;
  logic [BITS-1:0] obs_data;

  logic [BITS-1:0] t1_in  [FRAME] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd11, 8'd12, 8'd13, 8'd14,
                                      8'd21, 8'd22, 8'd23, 8'd24};
  logic [BITS-1:0] t1_out [FRAME] = '{8'd1, 8'd11, 8'd21, 8'd2, 8'd12, 8'd22, 8'd3, 8'd13,
                                      8'd23, 8'd4, 8'd14, 8'd24};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: a completed input frame yields its samples in interleaved order
  task automatic model_accept(input logic [BITS-1:0] din);
    exp_t e;
    in_buf[in_cnt] = din;
    in_cnt++;
    if (in_cnt == FRAME) begin
      for (int idx = 0; idx < N; idx++) begin
        for (int blk = 0; blk < IIR; blk++) begin
          e.d = in_buf[blk * N + idx];
          e.f = (idx == 0) && (blk == 0);
          e.l = (idx == N - 1) && (blk == IIR - 1);
          exp_q.push_back(e);
        end
      end
      in_cnt = 0;
    end
  endtask

  // Called at a falling edge: drive inputs, sample outputs, score the coming rising edge
  task automatic tick(input logic iv, input logic [BITS-1:0] din, input logic ordy);
    exp_t e;
    in_valid  = iv;
    data_in   = din;
    out_ready = ordy;
    #1;
    obs_valid    = out_valid;
    obs_data     = data_out;
    obs_first    = out_first;
    obs_last     = out_last;
    obs_in_ready = in_ready;
    if (hold_pending) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(data_out), 32'(hold_data));
      check("stall_flags", 32'({out_first, out_last}), 32'(hold_flags));
    end
    hold_pending = out_valid && !ordy;
    hold_data    = data_out;
    hold_flags   = {out_first, out_last};
    if (out_valid && ordy) begin
      $display("out xfer=%0d data=%0d first=%0b last=%0b", xfer_cnt, data_out, out_first, out_last);
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(data_out), 32'(e.d));
        check("out_flags", 32'({out_first, out_last}), 32'({e.f, e.l}));
      end
      got_q.push_back(data_out);
      xfer_cnt++;
    end
    if (out_valid) begin
      if (first_vt < 0) first_vt = tick_no;
      last_vt = tick_no;
      vcount++;
    end
    if (iv && in_ready) begin
      model_accept(din);
      acc_cnt++;
    end
    tick_no++;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 400;
    while (exp_q.size() > 0 && budget > 0) begin
      tick(1'b0, '0, 1'b1);
      budget--;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Entered at a falling edge; reset is asserted and released away from the rising edge
  task automatic do_reset(input string tag);
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
    check({tag, "_flags"}, 32'({out_first, out_last}), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    exp_q.delete();
    in_cnt       = 0;
    hold_pending = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    @(negedge clk);
    do_reset("rst0");

    // 1: single frame, latency and literal interleaved order
    got_q.delete();
    for (int k = 0; k < FRAME; k++) tick(1'b1, t1_in[k], 1'b1);
    tick(1'b0, '0, 1'b1);
    check("t1_latency_idle", 32'(obs_valid), 32'd0);
    tick(1'b0, '0, 1'b1);
    check("t1_first_valid", 32'(obs_valid), 32'd1);
    check("t1_first_data", 32'(obs_data), 32'd1);
    check("t1_first_flag", 32'(obs_first), 32'd1);
    drain("t1");
    check("t1_count", 32'(got_q.size()), 32'(FRAME));
    for (int k = 0; k < FRAME && k < got_q.size(); k++) check("t1_order", 32'(got_q[k]), 32'(t1_out[k]));

    // 2: three back-to-back frames, gapless output, in_ready never drops
    first_vt = -1;
    vcount   = 0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      tick(1'b1, BITS'(k + 1), 1'b1);
      check("t2_in_ready", 32'(obs_in_ready), 32'd1);
    end
    drain("t2");
    check("t2_valid_cycles", 32'(vcount), 32'd36);
    check("t2_valid_span", 32'(last_vt - first_vt + 1), 32'd36);

    // 3: downstream stalled, both banks fill, then drain
    for (int k = 0; k < 2 * FRAME; k++) begin
      tick(1'b1, BITS'(k + 1), 1'b0);
      check("t3_in_ready_fill", 32'(obs_in_ready), 32'd1);
    end
    tick(1'b1, 8'd99, 1'b0);
    check("t3_in_ready_full", 32'(obs_in_ready), 32'd0);
    check("t3_held_valid", 32'(obs_valid), 32'd1);
    check("t3_held_data", 32'(obs_data), 32'd1);
    check("t3_held_first", 32'(obs_first), 32'd1);
    for (int k = 0; k < 3; k++) tick(1'b1, 8'd98, 1'b0);
    drain("t3");
    tick(1'b0, '0, 1'b1);
    check("t3_in_ready_after", 32'(obs_in_ready), 32'd1);

    // 4: random valid/ready over five frames
    start = acc_cnt;
    for (int budget = 3000; budget > 0 && (acc_cnt - start) < 5 * FRAME; budget--)
      tick(1'($urandom_range(0, 1)), BITS'($urandom), 1'($urandom_range(0, 1)));
    check("t4_accepted", 32'(acc_cnt - start), 32'(5 * FRAME));
    drain("t4");

    // 5: reset after a partial frame
    for (int k = 0; k < 5; k++) tick(1'b1, BITS'(200 + k), 1'b1);
    do_reset("t5_rst");
    for (int k = 0; k < FRAME; k++) tick(1'b1, BITS'(40 + k), 1'b1);
    drain("t5");

    // 6: reset mid-stream with both banks full
    for (int k = 0; k < 2 * FRAME; k++) tick(1'b1, BITS'(60 + k), 1'b0);
    start = xfer_cnt;
    for (int budget = 100; budget > 0 && (xfer_cnt - start) < 7; budget--) tick(1'b0, '0, 1'b1);
    check("t6_reached_7", 32'(xfer_cnt - start), 32'd7);
    do_reset("t6_rst");
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, '0, 1'b1);
      check("t6_no_residue", 32'(obs_valid), 32'd0);
    end
    for (int k = 0; k < FRAME; k++) tick(1'b1, BITS'(120 + k), 1'b1);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
